// File: rtl/mul_div_unit_pkg.sv
// Shared CPU package: multiply/divide op encodings, latency defaults and the
// MDU state encoding, also used by the decoder and hazard unit.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MUL_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF = 10;
    localparam int unsigned CNT_W          = 4;

    function automatic logic is_md_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: the result is computed at launch and
// held until the latency counter expires, then committed to HI/LO.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [31:0]        hi_nxt, lo_nxt;
    logic [31:0]        res_hi, res_lo, res_hi_nxt, res_lo_nxt;
    logic               div0_q, div0_nxt;

    logic signed [31:0] a_s, b_s;
    logic signed [63:0] a_x, b_x, prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] calc_hi, calc_lo;
    logic               div0;

    assign a_s    = $signed(a);
    assign b_s    = $signed(b);
    assign a_x    = {{32{a[31]}}, a};
    assign b_x    = {{32{b[31]}}, b};
    assign prod_s = a_x * b_x;
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign div0   = is_div_op(op) && (b == 32'd0);

    // Signed divide; the one overflowing case (-2^31 / -1) wraps to -2^31, rem 0.
    always_comb begin
        quot_s = '0;
        rem_s  = '0;
        if (b != 32'd0) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                quot_s = a_s;
            end else begin
                quot_s = a_s / b_s;
                rem_s  = a_s % b_s;
            end
        end
    end

    always_comb begin
        calc_hi = '0;
        calc_lo = '0;
        case (op)
            OP_MULT:  {calc_hi, calc_lo} = prod_s;
            OP_MULTU: {calc_hi, calc_lo} = prod_u;
            OP_DIV: begin
                calc_hi = rem_s;
                calc_lo = quot_s;
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    calc_hi = a % b;
                    calc_lo = a / b;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hi_nxt     = hi;
        lo_nxt     = lo;
        res_hi_nxt = res_hi;
        res_lo_nxt = res_lo;
        div0_nxt   = div0_q;
        case (state)
            MD_IDLE: begin
                if (start && is_md_op(op)) begin
                    res_hi_nxt = calc_hi;
                    res_lo_nxt = calc_lo;
                    div0_nxt   = div0;
                    cnt_nxt    = is_div_op(op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
                    state_nxt  = MD_RUN;
                end else if (op == OP_MTHI) begin
                    hi_nxt = a;
                end else if (op == OP_MTLO) begin
                    lo_nxt = a;
                end
            end
            MD_RUN: begin
                // Requests arriving here are ignored; the hazard unit must hold them off.
                if (cnt == '0) begin
                    if (!div0_q) begin
                        hi_nxt = res_hi;
                        lo_nxt = res_lo;
                    end
                    state_nxt = MD_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            res_hi <= '0;
            res_lo <= '0;
            div0_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
            res_hi <= res_hi_nxt;
            res_lo <= res_lo_nxt;
            div0_q <= div0_nxt;
        end
    end

    assign busy = (state == MD_RUN);

endmodule
